// File: rtl/matmul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_pkg : shared types and constants for the matrix MAC controller
// Rev 1.0
// ----------------------------------------------------------------------------
package matmul_pkg;

  localparam int N_ROWS        = 128;
  localparam int BEATS_PER_ROW = 16;
  localparam int LANES         = 8;
  localparam int ACC_WIDTH     = 23;
  localparam int ROM_LAT       = 2;

  localparam int ROW_WIDTH     = $clog2(N_ROWS);
  localparam int CHUNK_WIDTH   = $clog2(BEATS_PER_ROW);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [ROW_WIDTH-1:0] row;
  } beat_tag_t;

endpackage
`default_nettype wire

// File: rtl/dot8_sum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dot8_sum : combinational 8-lane unsigned multiply with a balanced adder tree
// Rev 1.0
// ----------------------------------------------------------------------------
module dot8_sum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0][DATA_WIDTH-1:0] a_lo,
  input  logic [3:0][DATA_WIDTH-1:0] a_hi,
  input  logic [3:0][DATA_WIDTH-1:0] b_lo,
  input  logic [3:0][DATA_WIDTH-1:0] b_hi,
  output logic [2*DATA_WIDTH+2:0]    sum
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic [7:0][PROD_WIDTH-1:0] prod;
  logic [3:0][PROD_WIDTH:0]   sum_l1;
  logic [1:0][PROD_WIDTH+1:0] sum_l2;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign prod[i]     = PROD_WIDTH'(a_lo[i]) * PROD_WIDTH'(b_lo[i]);
    assign prod[i + 4] = PROD_WIDTH'(a_hi[i]) * PROD_WIDTH'(b_hi[i]);
  end

  for (genvar j = 0; j < 4; j++) begin : g_level1
    assign sum_l1[j] = {1'b0, prod[2*j]} + {1'b0, prod[2*j + 1]};
  end

  for (genvar j = 0; j < 2; j++) begin : g_level2
    assign sum_l2[j] = {1'b0, sum_l1[2*j]} + {1'b0, sum_l1[2*j + 1]};
  end

  assign sum = {1'b0, sum_l2[0]} + {1'b0, sum_l2[1]};

endmodule
`default_nettype wire

// File: rtl/matrix_mac_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_mac_controller : sequences ROM A/B/C reads, accumulates one dot
// product per row and checks it against the ROM C golden word.   Rev 1.0
// ----------------------------------------------------------------------------
module matrix_mac_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int ROM_LAT    = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  output logic [2*ADDR_WIDTH-1:0]          romA_addrA,
  output logic [2*ADDR_WIDTH-1:0]          romA_addrB,
  output logic [ADDR_WIDTH-1:0]            romB_addrA,
  output logic [ADDR_WIDTH-1:0]            romB_addrB,
  output logic [ADDR_WIDTH-1:0]            romC_addrA,
  output logic [ADDR_WIDTH-1:0]            romC_addrB,
  input  logic [3:0][DATA_WIDTH-1:0]       romA_busA_in,
  input  logic [3:0][DATA_WIDTH-1:0]       romA_busB_in,
  input  logic [3:0][DATA_WIDTH-1:0]       romB_busA_in,
  input  logic [3:0][DATA_WIDTH-1:0]       romB_busB_in,
  input  logic [2*DATA_WIDTH-1:0]          romC_dataA_in,
  input  logic [2*DATA_WIDTH-1:0]          romC_dataB_in,
  output logic                             busy,
  output logic                             done,
  output logic                             result_valid,
  output logic [ADDR_WIDTH-1:0]            result_row,
  output logic [2*DATA_WIDTH-1:0]          result_data,
  output logic                             mismatch,
  output logic [7:0]                       error_count,
  output logic                             pass
);

  import matmul_pkg::*;

  localparam int BEAT_WIDTH  = ADDR_WIDTH + CHUNK_WIDTH;
  localparam int DRAIN_WIDTH = $clog2(ROM_LAT + 1);
  localparam int SUM_WIDTH   = 2 * DATA_WIDTH + 3;
  localparam logic [DRAIN_WIDTH-1:0] DRAIN_LAST = DRAIN_WIDTH'(ROM_LAT);

  state_t                   state;
  state_t                   state_next;
  logic [BEAT_WIDTH-1:0]    beat;
  logic [DRAIN_WIDTH-1:0]   drain_cnt;
  logic                     issuing;
  logic [ADDR_WIDTH-1:0]    beat_row;
  logic [CHUNK_WIDTH-1:0]   beat_chunk;

  beat_tag_t                issue_tag;
  beat_tag_t [ROM_LAT-1:0]  tag_pipe;
  logic [ROM_LAT-1:0]       valid_pipe;
  beat_tag_t                data_tag;
  logic                     data_valid;

  logic [SUM_WIDTH-1:0]     beat_sum;
  logic [ACC_WIDTH-1:0]     acc;
  logic [ACC_WIDTH-1:0]     acc_next;
  logic                     row_mismatch;
  logic                     unused_romc_b;

  // Port B of ROM C mirrors port A and carries nothing new.
  assign unused_romc_b = ^romC_dataB_in;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      beat      <= (state == ST_ISSUE) ? beat + 1'b1 : '0;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_ISSUE;
      ST_ISSUE: begin
        busy = 1'b1;
        if (beat == '1) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- addressing
  assign issuing    = (state == ST_ISSUE);
  assign beat_row   = beat[BEAT_WIDTH-1 -: ADDR_WIDTH];
  assign beat_chunk = beat[CHUNK_WIDTH-1:0];

  // Each beat covers 8 consecutive elements: lanes 0-3 on port A, 4-7 on B.
  assign romA_addrA = issuing ? {beat_row, beat_chunk, 3'b000} : '0;
  assign romA_addrB = issuing ? {beat_row, beat_chunk, 3'b100} : '0;
  assign romB_addrA = issuing ? {beat_chunk, 3'b000} : '0;
  assign romB_addrB = issuing ? {beat_chunk, 3'b100} : '0;
  assign romC_addrA = issuing ? beat_row : '0;
  assign romC_addrB = issuing ? beat_row : '0;

  // ------------------------------------------------------- tag pipeline
  assign issue_tag.first = (beat_chunk == '0);
  assign issue_tag.last  = (beat_chunk == '1);
  assign issue_tag.row   = beat_row;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_pipe <= '0;
      tag_pipe   <= '0;
    end else begin
      valid_pipe[0] <= issuing;
      tag_pipe[0]   <= issue_tag;
      for (int s = 1; s < ROM_LAT; s++) begin
        valid_pipe[s] <= valid_pipe[s-1];
        tag_pipe[s]   <= tag_pipe[s-1];
      end
    end
  end

  assign data_valid = valid_pipe[ROM_LAT-1];
  assign data_tag   = tag_pipe[ROM_LAT-1];

  // ---------------------------------------------------------- datapath
  dot8_sum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dot8_sum (
    .a_lo (romA_busA_in),
    .a_hi (romA_busB_in),
    .b_lo (romB_busA_in),
    .b_hi (romB_busB_in),
    .sum  (beat_sum)
  );

  assign acc_next     = data_tag.first ? ACC_WIDTH'(beat_sum)
                                       : acc + ACC_WIDTH'(beat_sum);
  assign row_mismatch = (acc_next[2*DATA_WIDTH-1:0] != romC_dataA_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      result_valid <= 1'b0;
      result_row   <= '0;
      result_data  <= '0;
      mismatch     <= 1'b0;
      error_count  <= '0;
      pass         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      if (state == ST_IDLE && start) begin
        error_count <= '0;
        pass        <= 1'b0;
      end
      if (data_valid) begin
        acc <= acc_next;
        if (data_tag.last) begin
          result_valid <= 1'b1;
          result_row   <= data_tag.row;
          result_data  <= acc_next[2*DATA_WIDTH-1:0];
          mismatch     <= row_mismatch;
          if (row_mismatch && error_count != 8'hFF) begin
            error_count <= error_count + 8'd1;
          end
        end
      end
      // Last row result has landed by the final drain cycle.
      if (state == ST_DRAIN && state_next == ST_FINISH) begin
        pass <= (error_count == 8'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matrix_mac_controller : directed bench with a behavioural Matrices ROM
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_matrix_mac_controller;

  logic             clock;
  logic             reset;
  logic             start;
  logic [13:0]      romA_addrA, romA_addrB;
  logic [6:0]       romB_addrA, romB_addrB, romC_addrA, romC_addrB;
  logic [3:0][7:0]  romA_busA, romA_busB, romB_busA, romB_busB;
  logic [3:0][7:0]  a_a_s1, a_b_s1, b_a_s1, b_b_s1;
  logic [15:0]      c_s1, c_a;
  logic             busy, done, result_valid, mismatch, pass;
  logic [6:0]       result_row;
  logic [15:0]      result_data;
  logic [7:0]       error_count;

  logic [7:0]       mem_a [16384];
  logic [7:0]       mem_b [128];
  logic [15:0]      mem_c [128];
  logic [15:0]      exp_row [128];

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int last_mm_row;

  matrix_mac_controller #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (7),
    .ROM_LAT    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .romA_addrA    (romA_addrA),
    .romA_addrB    (romA_addrB),
    .romB_addrA    (romB_addrA),
    .romB_addrB    (romB_addrB),
    .romC_addrA    (romC_addrA),
    .romC_addrB    (romC_addrB),
    .romA_busA_in  (romA_busA),
    .romA_busB_in  (romA_busB),
    .romB_busA_in  (romB_busA),
    .romB_busB_in  (romB_busB),
    .romC_dataA_in (c_a),
    .romC_dataB_in (16'hBEEF),
    .busy          (busy),
    .done          (done),
    .result_valid  (result_valid),
    .result_row    (result_row),
    .result_data   (result_data),
    .mismatch      (mismatch),
    .error_count   (error_count),
    .pass          (pass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Two-register ROM: address in cycle t, data visible in cycle t+2.
  always @(posedge clock) begin
    for (int j = 0; j < 4; j++) begin
      a_a_s1[j] <= mem_a[int'(romA_addrA) + j];
      a_b_s1[j] <= mem_a[int'(romA_addrB) + j];
      b_a_s1[j] <= mem_b[int'(romB_addrA) + j];
      b_b_s1[j] <= mem_b[int'(romB_addrB) + j];
    end
    c_s1      <= mem_c[romC_addrA];
    romA_busA <= a_a_s1;
    romA_busB <= a_b_s1;
    romB_busA <= b_a_s1;
    romB_busB <= b_b_s1;
    c_a       <= c_s1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_expected();
    int s;
    for (int r = 0; r < 128; r++) begin
      s = 0;
      for (int c = 0; c < 128; c++) s += int'(mem_a[r*128 + c]) * int'(mem_b[c]);
      exp_row[r] = s[15:0];
    end
  endtask

  task automatic load_uniform(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    for (int i = 0; i < 16384; i++) mem_a[i] = a;
    for (int i = 0; i < 128; i++) begin
      mem_b[i] = b;
      mem_c[i] = c;
    end
    compute_expected();
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 16384; i++) mem_a[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 128; i++) mem_b[i] = 8'(i * 13 + 1);
    compute_expected();
    for (int i = 0; i < 128; i++) mem_c[i] = exp_row[i];
  endtask

  // Full run from start to the cycle after FINISH; t counts cycles from S.
  task automatic run_check(input bit poke_start, input bit check_addr);
    int bad_busy, bad_done, bad_rv, bad_row, bad_data, bad_mm, n_rv, exp_errs, r;
    logic exp_rv;
    bad_busy = 0; bad_done = 0; bad_rv = 0; bad_row = 0; bad_data = 0;
    bad_mm = 0; n_rv = 0; exp_errs = 0; last_mm_row = -1;
    for (int i = 0; i < 128; i++) if (exp_row[i] != mem_c[i]) exp_errs++;
    if (exp_errs > 255) exp_errs = 255;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared_at_start", error_count, 0);
    check("pass_cleared_at_start", pass, 0);
    for (int t = 0; t <= 2051; t++) begin
      if (t > 0) tick();
      start  = (poke_start && t == 500);
      exp_rv = (t >= 18 && t <= 2050 && ((t - 18) % 16) == 0);
      if (busy !== (t <= 2050)) bad_busy++;
      if (done !== (t == 2051)) bad_done++;
      if (result_valid !== exp_rv) bad_rv++;
      if (exp_rv) begin
        r = (t - 18) / 16;
        n_rv++;
        if (result_row !== 7'(r)) bad_row++;
        if (result_data !== exp_row[r]) bad_data++;
        if (mismatch !== (exp_row[r] != mem_c[r])) bad_mm++;
        if (mismatch === 1'b1) last_mm_row = int'(result_row);
      end else if (mismatch !== 1'b0) begin
        bad_mm++;
      end
      if (t == 18 || t == 2050) check("rv_edge", result_valid, 1);
      if (check_addr && t == 17) begin
        check("b17_romA_addrA", romA_addrA, 136);
        check("b17_romA_addrB", romA_addrB, 140);
        check("b17_romB_addrA", romB_addrA, 8);
        check("b17_romB_addrB", romB_addrB, 12);
        check("b17_romC_addrA", romC_addrA, 1);
      end
      if (check_addr && t == 2047) check("b2047_romA_addrB", romA_addrB, 16380);
    end
    check("done_at_2051", done, 1);
    check("busy_low_at_2051", busy, 0);
    check("error_count", error_count, 32'(exp_errs));
    check("pass", pass, (exp_errs == 0) ? 1 : 0);
    check("busy_timing_errors", bad_busy, 0);
    check("done_timing_errors", bad_done, 0);
    check("rv_timing_errors", bad_rv, 0);
    check("row_index_errors", bad_row, 0);
    check("row_data_errors", bad_data, 0);
    check("mismatch_flag_errors", bad_mm, 0);
    check("result_count", n_rv, 128);
    tick();
    check("done_single_pulse", done, 0);
    check("idle_romA_addrB", romA_addrB, 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b1;
    load_uniform(8'd1, 8'd1, 16'd128);
    repeat (3) tick();
    check("rst_romA_addrA", romA_addrA, 0);
    check("rst_romA_addrB", romA_addrB, 0);
    check("rst_romB_addrA", romB_addrA, 0);
    check("rst_romB_addrB", romB_addrB, 0);
    check("rst_romC_addrA", romC_addrA, 0);
    check("rst_romC_addrB", romC_addrB, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_row", result_row, 0);
    check("rst_result_data", result_data, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_error_count", error_count, 0);
    check("rst_pass", pass, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("no_busy_after_start_in_reset", busy, 0);

    // All-ones, with a stray start mid-run and address spot checks
    check("all_ones_expected_row", exp_row[0], 16'h0080);
    run_check(1'b1, 1'b1);

    // Truncation: 255*255*128 = 0x7F0080
    load_uniform(8'd255, 8'd255, 16'h0080);
    check("trunc_expected_row", exp_row[127], 16'h0080);
    run_check(1'b0, 1'b0);

    // Single corrupted golden word
    load_uniform(8'd1, 8'd1, 16'd128);
    mem_c[5] = 16'h1234;
    run_check(1'b0, 1'b0);
    check("mismatch_row", last_mm_row, 5);

    mem_c[5] = 16'd128;
    run_check(1'b0, 1'b0);

    // Non-uniform data exercises lane/address mapping
    load_pattern();
    run_check(1'b0, 1'b1);

    // Reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1000) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_romA_addrA", romA_addrA, 0);
    check("midrst_romB_addrB", romB_addrB, 0);
    check("midrst_romC_addrA", romC_addrA, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) seen++;
    end
    check("midrst_quiet", seen, 0);
    run_check(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
